// File: rtl/viewport_pkg.sv
// Shared types and helpers for the scrolling viewport controller:
// mode encodings, control FSM states and a signed clamp.
package viewport_pkg;

    typedef enum logic [1:0] {
        MODE_SNAP   = 2'b00,
        MODE_SMOOTH = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_FREEZE = 2'b11
    } vp_mode_e;

    typedef enum logic {
        ST_SETTLED = 1'b0,
        ST_PANNING = 1'b1
    } vp_state_e;

    // Wide enough for any COORD_W+2 signed intermediate we clamp.
    localparam int CALC_W = 32;

    function automatic logic signed [CALC_W-1:0] clamp_s(
        input logic signed [CALC_W-1:0] val,
        input logic signed [CALC_W-1:0] lo,
        input logic signed [CALC_W-1:0] hi
    );
        logic signed [CALC_W-1:0] res_s;
        if (val < lo) begin
            res_s = lo;
        end else if (val > hi) begin
            res_s = hi;
        end else begin
            res_s = val;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/vp_axis.sv
// One viewport axis: location capture, target clamp, applied offset
// register and the per-frame snap/smooth step toward the target.
module vp_axis
    import viewport_pkg::*;
#(
    parameter int COORD_W  = 8,
    parameter int MAP_N    = 256,
    parameter int WIN_N    = 64,
    parameter int STEP_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd,
    input  logic               frame_start,
    input  vp_mode_e           mode,
    input  logic [COORD_W-1:0] loc,
    input  logic [COORD_W-1:0] man,
    output logic [COORD_W-1:0] off,
    output logic               at_target,
    output logic               at_target_nxt
);

    localparam int HALF_C  = WIN_N / 2;
    localparam int LIMIT_C = MAP_N - WIN_N;
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP_MAX);

    logic [COORD_W-1:0]        loc_r;
    logic [COORD_W-1:0]        off_r;
    logic [COORD_W-1:0]        follow_tgt_s;
    logic [COORD_W-1:0]        man_tgt_s;
    logic [COORD_W-1:0]        target_s;
    logic [COORD_W-1:0]        gap_s;
    logic [COORD_W-1:0]        step_s;
    logic [COORD_W-1:0]        off_nxt_s;
    logic signed [COORD_W+1:0] follow_diff_s;

    // Location register: captured on each sysreg update pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loc_r <= {COORD_W{1'b0}};
        end else if (upd) begin
            loc_r <= loc;
        end else begin
            loc_r <= loc_r;
        end
    end

    // Centre the robot in the window; the extra two bits keep loc - WIN/2 signed.
    assign follow_diff_s = $signed({2'b00, loc_r}) - $signed((COORD_W+2)'(HALF_C));
    assign follow_tgt_s  = COORD_W'(clamp_s(32'(follow_diff_s), 32'sd0, 32'(LIMIT_C)));
    assign man_tgt_s     = COORD_W'(clamp_s($signed(32'(man)), 32'sd0, 32'(LIMIT_C)));

    // Target selection: manual requests bypass the follow computation.
    always_comb begin
        target_s = follow_tgt_s;
        if (mode == MODE_MANUAL) begin
            target_s = man_tgt_s;
        end else begin
            target_s = follow_tgt_s;
        end
    end

    // Distance to target and the bounded smooth-follow step.
    always_comb begin
        gap_s  = {COORD_W{1'b0}};
        step_s = {COORD_W{1'b0}};
        if (target_s > off_r) begin
            gap_s = target_s - off_r;
        end else begin
            gap_s = off_r - target_s;
        end
        if (gap_s > STEP_C) begin
            step_s = STEP_C;
        end else begin
            step_s = gap_s;
        end
    end

    // Next offset: only a frame boundary may move it.
    always_comb begin
        off_nxt_s = off_r;
        if (frame_start) begin
            case (mode)
                MODE_SNAP, MODE_MANUAL: off_nxt_s = target_s;
                MODE_SMOOTH: begin
                    if (target_s > off_r) begin
                        off_nxt_s = off_r + step_s;
                    end else begin
                        off_nxt_s = off_r - step_s;
                    end
                end
                MODE_FREEZE: off_nxt_s = off_r;
                default:     off_nxt_s = off_r;
            endcase
        end else begin
            off_nxt_s = off_r;
        end
    end

    // Applied offset register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_r <= {COORD_W{1'b0}};
        end else begin
            off_r <= off_nxt_s;
        end
    end

    assign off           = off_r;
    assign at_target     = (off_r == target_s);
    assign at_target_nxt = (off_nxt_s == target_s);

endmodule

// File: rtl/viewport_ctrl.sv
// Rojobot viewport controller: per-axis offset tracking, pan status FSM
// and the registered viewport-to-world address translation.
module viewport_ctrl
    import viewport_pkg::*;
#(
    parameter int COORD_W  = 8,
    parameter int ADDR_W   = 11,
    parameter int MAP_W    = 256,
    parameter int MAP_H    = 256,
    parameter int WIN_W    = 64,
    parameter int WIN_H    = 64,
    parameter int STEP_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] loc_x,
    input  logic [COORD_W-1:0] loc_y,
    input  logic               upd_sysregs,
    input  logic               frame_start,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] man_x,
    input  logic [COORD_W-1:0] man_y,
    input  logic [ADDR_W-1:0]  vid_row,
    input  logic [ADDR_W-1:0]  vid_col,
    output logic [ADDR_W-1:0]  map_row,
    output logic [ADDR_W-1:0]  map_col,
    output logic               map_valid,
    output logic [COORD_W-1:0] off_x,
    output logic [COORD_W-1:0] off_y,
    output logic               panning
);

    vp_mode_e           mode_s;
    vp_state_e          state_r;
    vp_state_e          state_nxt_s;
    logic               x_at_s;
    logic               y_at_s;
    logic               x_at_nxt_s;
    logic               y_at_nxt_s;
    logic               win_hit_s;
    logic [ADDR_W-1:0]  map_row_r;
    logic [ADDR_W-1:0]  map_col_r;
    logic               map_valid_r;

    assign mode_s = vp_mode_e'(mode);

    vp_axis #(
        .COORD_W  (COORD_W),
        .MAP_N    (MAP_W),
        .WIN_N    (WIN_W),
        .STEP_MAX (STEP_MAX)
    ) u_axis_x (
        .clk           (clk),
        .reset         (reset),
        .upd           (upd_sysregs),
        .frame_start   (frame_start),
        .mode          (mode_s),
        .loc           (loc_x),
        .man           (man_x),
        .off           (off_x),
        .at_target     (x_at_s),
        .at_target_nxt (x_at_nxt_s)
    );

    vp_axis #(
        .COORD_W  (COORD_W),
        .MAP_N    (MAP_H),
        .WIN_N    (WIN_H),
        .STEP_MAX (STEP_MAX)
    ) u_axis_y (
        .clk           (clk),
        .reset         (reset),
        .upd           (upd_sysregs),
        .frame_start   (frame_start),
        .mode          (mode_s),
        .loc           (loc_y),
        .man           (man_y),
        .off           (off_y),
        .at_target     (y_at_s),
        .at_target_nxt (y_at_nxt_s)
    );

    // Pan FSM next state: a frame update decides from the post-update offsets,
    // otherwise a moving target can still be met between frames.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SETTLED: begin
                if (frame_start && !(x_at_nxt_s && y_at_nxt_s)) begin
                    state_nxt_s = ST_PANNING;
                end else begin
                    state_nxt_s = ST_SETTLED;
                end
            end
            ST_PANNING: begin
                if (frame_start) begin
                    state_nxt_s = (x_at_nxt_s && y_at_nxt_s) ? ST_SETTLED : ST_PANNING;
                end else if (x_at_s && y_at_s) begin
                    state_nxt_s = ST_SETTLED;
                end else begin
                    state_nxt_s = ST_PANNING;
                end
            end
            default: state_nxt_s = ST_SETTLED;
        endcase
    end

    // Pan FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_SETTLED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign panning   = (state_r == ST_PANNING);
    assign win_hit_s = (vid_row < ADDR_W'(WIN_H)) && (vid_col < ADDR_W'(WIN_W));

    // Address translation uses the offsets held at the start of this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_row_r   <= {ADDR_W{1'b0}};
            map_col_r   <= {ADDR_W{1'b0}};
            map_valid_r <= 1'b0;
        end else if (win_hit_s) begin
            map_row_r   <= vid_row + ADDR_W'(off_y);
            map_col_r   <= vid_col + ADDR_W'(off_x);
            map_valid_r <= 1'b1;
        end else begin
            map_row_r   <= {ADDR_W{1'b0}};
            map_col_r   <= {ADDR_W{1'b0}};
            map_valid_r <= 1'b0;
        end
    end

    assign map_row   = map_row_r;
    assign map_col   = map_col_r;
    assign map_valid = map_valid_r;

endmodule

// File: tb/tb_viewport_ctrl.sv
// Self-checking bench for viewport_ctrl: hand-written frame sequences for the
// offset/FSM behaviour and a scoreboarded vector table for the address path.
module tb_viewport_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  loc_x;
    logic [7:0]  loc_y;
    logic        upd_sysregs;
    logic        frame_start;
    logic [1:0]  mode;
    logic [7:0]  man_x;
    logic [7:0]  man_y;
    logic [10:0] vid_row;
    logic [10:0] vid_col;
    logic [10:0] map_row;
    logic [10:0] map_col;
    logic        map_valid;
    logic [7:0]  off_x;
    logic [7:0]  off_y;
    logic        panning;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] vr;
        logic [10:0] vc;
        logic [10:0] er;
        logic [10:0] ec;
        logic        ev;
    } addr_vec_t;

    addr_vec_t tbl[11];
    addr_vec_t sb[$];

    viewport_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .loc_x       (loc_x),
        .loc_y       (loc_y),
        .upd_sysregs (upd_sysregs),
        .frame_start (frame_start),
        .mode        (mode),
        .man_x       (man_x),
        .man_y       (man_y),
        .vid_row     (vid_row),
        .vid_col     (vid_col),
        .map_row     (map_row),
        .map_col     (map_col),
        .map_valid   (map_valid),
        .off_x       (off_x),
        .off_y       (off_y),
        .panning     (panning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_off(input string nm, input int x, input int y, input int p);
        chk({nm, ".off_x"}, int'(off_x), x);
        chk({nm, ".off_y"}, int'(off_y), y);
        chk({nm, ".panning"}, int'(panning), p);
    endtask

    task automatic do_upd(input int x, input int y);
        @(negedge clk);
        loc_x = 8'(x);
        loc_y = 8'(y);
        upd_sysregs = 1'b1;
        @(negedge clk);
        upd_sysregs = 1'b0;
    endtask

    task automatic do_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic cmp_addr(input addr_vec_t e);
        chk("map_row", int'(map_row), int'(e.er));
        chk("map_col", int'(map_col), int'(e.ec));
        chk("map_valid", int'(map_valid), int'(e.ev));
    endtask

    // Streams vectors back to back; each result is checked one cycle after it was driven.
    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            if (sb.size() > 0) cmp_addr(sb.pop_front());
            vid_row = tbl[i].vr;
            vid_col = tbl[i].vc;
            sb.push_back(tbl[i]);
        end
        @(negedge clk);
        if (sb.size() > 0) cmp_addr(sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // offsets (68,68): loc=(100,100)
        tbl[0]  = '{11'd5,    11'd7,    11'd73,  11'd75,  1'b1};
        tbl[1]  = '{11'd0,    11'd0,    11'd68,  11'd68,  1'b1};
        tbl[2]  = '{11'd63,   11'd63,   11'd131, 11'd131, 1'b1};
        tbl[3]  = '{11'd0,    11'd64,   11'd0,   11'd0,   1'b0};
        tbl[4]  = '{11'd64,   11'd0,    11'd0,   11'd0,   1'b0};
        tbl[5]  = '{11'd2047, 11'd2047, 11'd0,   11'd0,   1'b0};
        // offsets (x=192,y=0): loc=(230,10)
        tbl[6]  = '{11'd10,   11'd20,   11'd10,  11'd212, 1'b1};
        tbl[7]  = '{11'd63,   11'd63,   11'd63,  11'd255, 1'b1};
        tbl[8]  = '{11'd0,    11'd63,   11'd0,   11'd255, 1'b1};
        tbl[9]  = '{11'd64,   11'd64,   11'd0,   11'd0,   1'b0};
        tbl[10] = '{11'd1,    11'd1,    11'd1,   11'd193, 1'b1};

        reset = 1'b1;
        loc_x = 8'd0;  loc_y = 8'd0;
        upd_sysregs = 1'b0;
        frame_start = 1'b0;
        mode  = 2'b00;
        man_x = 8'd0;  man_y = 8'd0;
        vid_row = 11'd0; vid_col = 11'd0;
        repeat (2) @(negedge clk);
        chk_off("reset", 0, 0, 0);
        chk("reset.map_valid", int'(map_valid), 0);
        chk("reset.map_row", int'(map_row), 0);
        reset = 1'b0;

        // Snap with clamps at the low edge and mid-range
        do_upd(10, 200);
        do_frame();
        chk_off("snap_10_200", 0, 168, 0);
        do_upd(32, 224);
        do_frame();
        chk_off("snap_edges", 0, 192, 0);

        // Offsets must not move without frame_start
        do_upd(150, 150);
        repeat (3) @(negedge clk);
        chk_off("no_frame_hold", 0, 192, 0);

        // Coincident update and frame uses the old location
        do_upd(50, 50);
        do_frame();
        chk_off("snap_50", 18, 18, 0);
        @(negedge clk);
        loc_x = 8'd200; loc_y = 8'd200;
        upd_sysregs = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        upd_sysregs = 1'b0; frame_start = 1'b0;
        chk_off("coincident", 18, 18, 0);
        do_frame();
        chk_off("after_coincident", 168, 168, 0);

        // Smooth follow from (0,0) toward targets (28,8)
        do_upd(0, 0);
        do_frame();
        chk_off("smooth_home", 0, 0, 0);
        mode = 2'b01;
        do_upd(60, 40);
        do_frame(); chk_off("smooth_f1", 4, 4, 1);
        do_frame(); chk_off("smooth_f2", 8, 8, 1);
        do_frame(); chk_off("smooth_f3", 12, 8, 1);
        do_frame(); chk_off("smooth_f4", 16, 8, 1);
        do_frame(); chk_off("smooth_f5", 20, 8, 1);
        do_frame(); chk_off("smooth_f6", 24, 8, 1);
        do_frame(); chk_off("smooth_f7", 28, 8, 0);

        // Freeze holds offsets while the location still updates
        mode = 2'b11;
        do_upd(200, 200);
        do_frame();
        chk_off("freeze", 28, 8, 1);
        mode = 2'b00;
        do_frame();
        chk_off("unfreeze_snap", 168, 168, 0);

        // Manual with clamping
        mode  = 2'b10;
        man_x = 8'd250; man_y = 8'd5;
        do_frame();
        chk_off("manual", 192, 5, 0);

        // Reset mid-pan is asynchronous and forgets the location
        mode = 2'b01;
        do_frame();
        chk_off("pan_before_reset", 188, 9, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_off("async_reset", 0, 0, 0);
        chk("async_reset.map_valid", int'(map_valid), 0);
        chk("async_reset.map_col", int'(map_col), 0);
        @(negedge clk);
        reset = 1'b0;
        do_frame();
        chk_off("post_reset_frame", 0, 0, 0);

        // Address path, first offset set
        mode = 2'b00;
        do_upd(100, 100);
        do_frame();
        chk_off("addr_setup1", 68, 68, 0);
        run_table(0, 5);

        // Address path, second offset set
        do_upd(230, 10);
        do_frame();
        chk_off("addr_setup2", 192, 0, 0);
        run_table(6, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
